melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Programmable note sequencer that feeds the notes ROM / PWM chain in place of the fixed free-running sequence counter.
- Holds a small writable melody memory of {note, duration} entries and steps through it on strobe ticks from the strobe generator.
- Drives a note index and a gate; supports play, stop, loop, rests and end-of-melody markers.

Parameters:
- SEQ_LEN, 16, number of melody entries (power of two); address width AW = clog2(SEQ_LEN).
- NOTE_W, 6, note index width; matches the notes ROM index.
- DUR_W, 4, duration field width, in strobe units.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- strb_i  in  1  one-cycle tick from the strobe generator; the duration time base.
- wr_en_i  in  1  melody memory write strobe.
- wr_addr_i  in  AW  write address.
- wr_data_i  in  NOTE_W+DUR_W  entry {note[NOTE_W-1:0] in MSBs, dur[DUR_W-1:0] in LSBs}.
- play_i  in  1  start request, level-sampled.
- stop_i  in  1  abort request, level-sampled.
- loop_i  in  1  when 1, the melody restarts at entry 0 after its end.
- note_index_o  out  NOTE_W  current note index to the notes ROM.
- note_valid_o  out  1  gate; 1 while a non-rest note plays.
- busy_o  out  1  sequencer is in FETCH or PLAY.
- step_o  out  AW  address of the current entry.
- done_o  out  1  one-cycle pulse when the melody ends without looping.

Behaviour:
- Reset (async assert, sync-released use): state IDLE; all outputs 0; address 0; remaining counter 0. Memory contents are not reset.
- Entry semantics: dur==0 is the end marker. note==0 is a rest; it plays for dur, but note_valid_o=0.
- Memory: synchronous write, synchronous registered read (1 cycle). A write and a fetch to the same address in the same cycle return the old data.
- Writes are accepted in every state.
- IDLE: play_i=1 and stop_i=0 -> FETCH with address 0.
- FETCH: lasts one cycle; strb_i is ignored. Outputs hold their previous values. Next cycle, the read data is evaluated:
  - dur!=0 -> PLAY. Set note_index_o=note, note_valid_o=(note!=0), step_o=address, remaining=dur.
  - dur==0 and loop_i=1 and address!=0 -> FETCH at address 0.
  - dur==0 and (loop_i=0 or address==0) -> IDLE, with done_o pulse, note_valid_o=0, note_index_o=0. This rule prevents an infinite loop on an empty melody.
- PLAY, on strb_i:
  - remaining>1 -> decrement.
  - remaining==1 -> advance. If address==SEQ_LEN-1: with loop_i=1, FETCH at 0; with loop_i=0, IDLE plus done_o pulse. Otherwise, FETCH at address+1.
- A note therefore lasts exactly dur strobes counted after entry into PLAY, plus one FETCH cycle.
- Latency: play_i high in cycle N -> busy_o=1 in N+1 (FETCH) -> note outputs valid in N+2.
- stop_i=1 in any state -> IDLE next cycle; note_valid_o=0, note_index_o=0, address 0, no done_o. stop_i wins over a simultaneous play_i.
- play_i while busy is ignored; play_i held high after done restarts the melody from IDLE.
- loop_i is sampled only at end/wrap decisions.
- busy_o is registered: 1 in FETCH/PLAY, 0 in IDLE.

Optional Feature:
- MELODY_SEQ_TEMPO_EN.
- When defined: adds port tempo_i (in, 4 bits) and an internal 4-bit prescaler. One duration unit = tempo_i+1 strobes. The prescaler clears on each entry into PLAY. tempo_i is sampled on every strobe.
- When undefined: no port and no prescaler; one duration unit = one strobe.

Test Plan:
- Load entries 0:{5,2}, 1:{9,1}, 2:{0,0}; play_i pulse at cycle N, strobes every 10 cycles. Required: busy_o=1 at N+1; note 5 with valid=1 at N+2 for 2 strobes; then note 9 for 1 strobe; then done_o pulse, busy_o=0, note_valid_o=0.
- Rest: entry 0:{0,3}, entry 1:{0,0}. Required: note_valid_o stays 0 for 3 strobes, then done_o.
- Loop: entries {7,1},{0,0} with loop_i=1. Required: note 7 repeats indefinitely, done_o never fires. Then assert stop_i: IDLE next cycle, outputs 0, no done_o.
- Empty melody: entry 0 = {x,0}, loop_i=1, play. Required: done_o 2 cycles after play_i, no hang.
- Wrap: SEQ_LEN=16 with all entries {n,1}, loop_i=0. Required: step_o runs 0..15 then done_o. With loop_i=1, step_o returns to 0.
- Async reset asserted mid-PLAY and between clock edges. Required: all outputs 0 immediately. With MELODY_SEQ_TEMPO_EN and tempo_i=2, a dur=2 note lasts 6 strobes.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - write/control/status bundle of the melody sequencer
//
// Groups every melody_sequencer signal except clock and reset.
//   strb_i        duration time-base tick
//   wr_en_i/wr_addr_i/wr_data_i  melody memory write port, data = {note, dur}
//   play_i/stop_i/loop_i         transport controls (level-sampled)
//   tempo_i       duration unit = tempo_i+1 strobes (MELODY_SEQ_TEMPO_EN only)
//   note_index_o/note_valid_o    note to the notes ROM and its gate
//   busy_o/step_o/done_o         status: running, current entry, end pulse
// master drives the controls (bench / host), slave is the sequencer.
// Optional feature macro: MELODY_SEQ_TEMPO_EN.
interface melody_sequencer_if #(
    parameter int SEQ_LEN = 16,
    parameter int NOTE_W  = 6,
    parameter int DUR_W   = 4
);
    localparam int AW = $clog2(SEQ_LEN);

    logic                    strb_i;
    logic                    wr_en_i;
    logic [AW-1:0]           wr_addr_i;
    logic [NOTE_W+DUR_W-1:0] wr_data_i;
    logic                    play_i;
    logic                    stop_i;
    logic                    loop_i;
`ifdef MELODY_SEQ_TEMPO_EN
    logic [3:0]              tempo_i;
`endif
    logic [NOTE_W-1:0]       note_index_o;
    logic                    note_valid_o;
    logic                    busy_o;
    logic [AW-1:0]           step_o;
    logic                    done_o;

    modport master (
`ifdef MELODY_SEQ_TEMPO_EN
        output tempo_i,
`endif
        output strb_i, wr_en_i, wr_addr_i, wr_data_i, play_i, stop_i, loop_i,
        input  note_index_o, note_valid_o, busy_o, step_o, done_o
    );

    modport slave (
`ifdef MELODY_SEQ_TEMPO_EN
        input  tempo_i,
`endif
        input  strb_i, wr_en_i, wr_addr_i, wr_data_i, play_i, stop_i, loop_i,
        output note_index_o, note_valid_o, busy_o, step_o, done_o
    );
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - programmable {note, duration} melody sequencer
//
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   bus      melody_sequencer_if.slave (memory write port, play/stop/loop,
//            strobe, note/gate/status outputs)
// Steps through a writable melody memory on strobe ticks. dur==0 marks the
// end of the melody, note==0 is a rest (plays its duration with the gate low).
// Optional feature macro: MELODY_SEQ_TEMPO_EN (tempo_i prescaler, one
// duration unit = tempo_i+1 strobes).
module melody_sequencer #(
    parameter int SEQ_LEN = 16,
    parameter int NOTE_W  = 6,
    parameter int DUR_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    melody_sequencer_if.slave   bus
);
    localparam int AW    = $clog2(SEQ_LEN);
    localparam int ENT_W = NOTE_W + DUR_W;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(SEQ_LEN - 1);
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [AW-1:0]      addr_q, addr_n;
    logic [DUR_W-1:0]   rem_q, rem_n;
    logic [NOTE_W-1:0]  note_q, note_n;
    logic               valid_q, valid_n;
    logic               busy_q, busy_n;
    logic [AW-1:0]      step_q, step_n;
    logic               done_q, done_n;
    logic               to_idle;
    logic               unit_tick;

    logic [ENT_W-1:0]   mem [SEQ_LEN];
    logic [ENT_W-1:0]   rd_q;
    logic [NOTE_W-1:0]  rd_note;
    logic [DUR_W-1:0]   rd_dur;

    assign rd_note = rd_q[ENT_W-1:DUR_W];
    assign rd_dur  = rd_q[DUR_W-1:0];

`ifdef MELODY_SEQ_TEMPO_EN
    logic [3:0] psc_q, psc_n;
    // A duration unit elapses on the strobe that completes tempo_i+1 strobes.
    assign unit_tick = bus.strb_i && (psc_q == bus.tempo_i);
`else
    assign unit_tick = bus.strb_i;
`endif

    // The read address is the next-cycle address, so the entry is already in
    // rd_q during the single FETCH cycle and can be evaluated at its end.
    // Read-before-write: a same-cycle write to that address returns old data.
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
        rd_q <= mem[addr_n];
    end

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        rem_n   = rem_q;
        note_n  = note_q;
        valid_n = valid_q;
        step_n  = step_q;
        done_n  = 1'b0;
        to_idle = 1'b0;
`ifdef MELODY_SEQ_TEMPO_EN
        psc_n   = psc_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.play_i) begin
                    state_n = FETCH;
                    addr_n  = '0;
                end
            end
            FETCH: begin
                if (rd_dur != '0) begin
                    state_n = PLAY;
                    note_n  = rd_note;
                    valid_n = |rd_note;
                    step_n  = addr_q;
                    rem_n   = rd_dur;
`ifdef MELODY_SEQ_TEMPO_EN
                    psc_n   = '0;
`endif
                end else if (bus.loop_i && addr_q != '0) begin
                    addr_n = '0;
                end else begin
                    // End marker at entry 0 never loops: empty melody ends.
                    to_idle = 1'b1;
                    done_n  = 1'b1;
                end
            end
            PLAY: begin
`ifdef MELODY_SEQ_TEMPO_EN
                if (bus.strb_i) begin
                    psc_n = unit_tick ? 4'd0 : psc_q + 4'd1;
                end
`endif
                if (unit_tick) begin
                    if (rem_q != DUR_ONE) begin
                        rem_n = rem_q - DUR_ONE;
                    end else if (addr_q == LAST_ADDR) begin
                        if (bus.loop_i) begin
                            state_n = FETCH;
                            addr_n  = '0;
                        end else begin
                            to_idle = 1'b1;
                            done_n  = 1'b1;
                        end
                    end else begin
                        state_n = FETCH;
                        addr_n  = addr_q + AW'(1);
                    end
                end
            end
            default: begin
                to_idle = 1'b1;
            end
        endcase

        if (bus.stop_i) begin
            to_idle = 1'b1;
            done_n  = 1'b0;
        end

        if (to_idle) begin
            state_n = IDLE;
            addr_n  = '0;
            rem_n   = '0;
            note_n  = '0;
            valid_n = 1'b0;
            step_n  = '0;
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= '0;
            done_q  <= 1'b0;
`ifdef MELODY_SEQ_TEMPO_EN
            psc_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            rem_q   <= rem_n;
            note_q  <= note_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            step_q  <= step_n;
            done_q  <= done_n;
`ifdef MELODY_SEQ_TEMPO_EN
            psc_q   <= psc_n;
`endif
        end
    end

    assign bus.note_index_o = note_q;
    assign bus.note_valid_o = valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.step_o       = step_q;
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer
module tb_melody_sequencer;
    localparam int SEQ_LEN = 16;
    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 4;
    localparam int AW      = 4;
    localparam int MAXC    = 700;
`ifdef MELODY_SEQ_TEMPO_EN
    localparam int TEMPO = 2;
`else
    localparam int TEMPO = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    melody_sequencer_if #(.SEQ_LEN(SEQ_LEN), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

    melody_sequencer #(.SEQ_LEN(SEQ_LEN), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [NOTE_W+DUR_W-1:0] mem_m [SEQ_LEN];
    bit                      strb_pat [MAXC];
    logic [12:0]             exp_v [MAXC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {busy, done, valid, step, note}
    function automatic logic [12:0] pack(input bit b, input bit d, input bit v,
                                         input int s, input logic [NOTE_W-1:0] n);
        logic [AW-1:0] s4;
        s4 = s[AW-1:0];
        return {b, d, v, s4, n};
    endfunction

    function automatic logic [12:0] obs();
        return {bus.busy_o, bus.done_o, bus.note_valid_o, bus.step_o, bus.note_index_o};
    endfunction

    // Event-level timeline: play pulse in cycle 0, FETCH in cycle 1. An entry
    // entered at cycle t plays from t+1 until its dur*(TEMPO+1)-th strobe in
    // cycle s; the next FETCH is cycle s+1. End of melody -> done next cycle.
    task automatic build_exp(input int ncyc, input bit lp, input int stop_at);
        int t, a, c, cnt, need, dur, st;
        logic [NOTE_W-1:0] nt;
        bit vl, fin;
        for (int i = 0; i < MAXC; i++) exp_v[i] = '0;
        t = 1; a = 0; nt = '0; vl = 0; st = 0; fin = 0;
        while (!fin && t <= ncyc) begin
            exp_v[t] = pack(1, 0, vl, st, nt);
            dur = int'(mem_m[a][DUR_W-1:0]);
            if (dur != 0) begin
                nt = mem_m[a][NOTE_W+DUR_W-1:DUR_W];
                vl = (nt != 0);
                st = a;
                need = dur * (TEMPO + 1);
                c = t; cnt = 0;
                while (cnt < need && c < ncyc) begin
                    c++;
                    exp_v[c] = pack(1, 0, vl, st, nt);
                    if (strb_pat[c]) cnt++;
                end
                if (cnt < need) begin
                    fin = 1;
                end else if (a == SEQ_LEN - 1 && !lp) begin
                    exp_v[c+1] = pack(0, 1, 0, 0, '0);
                    fin = 1;
                end else begin
                    a = (a == SEQ_LEN - 1) ? 0 : a + 1;
                    t = c + 1;
                end
            end else if (lp && a != 0) begin
                a = 0;
                t++;
            end else begin
                exp_v[t+1] = pack(0, 1, 0, 0, '0);
                fin = 1;
            end
        end
        if (stop_at >= 0) begin
            for (int i = stop_at + 1; i < MAXC; i++) exp_v[i] = '0;
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < SEQ_LEN; i++) begin
            @(negedge clk);
            bus.wr_en_i   = 1'b1;
            bus.wr_addr_i = AW'(i);
            bus.wr_data_i = mem_m[i];
        end
        @(negedge clk);
        bus.wr_en_i = 1'b0;
    endtask

    task automatic set_strb(input bit rnd, input int period);
        for (int i = 0; i < MAXC; i++) begin
            if (rnd) strb_pat[i] = ($urandom_range(0, 2) == 0);
            else     strb_pat[i] = ((i % period) == period - 1);
        end
    endtask

    task automatic run(input string name, input int ncyc, input bit lp, input int stop_at);
        build_exp(ncyc, lp, stop_at);
        bus.loop_i = lp;
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", name, c), 32'(obs()), 32'(exp_v[c]));
            bus.play_i = (c == 0);
            bus.stop_i = (c == stop_at);
            bus.strb_i = strb_pat[c];
        end
        @(negedge clk);
        bus.play_i = 1'b0;
        bus.strb_i = 1'b0;
        bus.stop_i = 1'b1;
        @(negedge clk);
        bus.stop_i = 1'b0;
    endtask

    function automatic logic [9:0] ent(input int n, input int d);
        logic [NOTE_W-1:0] n6;
        logic [DUR_W-1:0]  d4;
        n6 = n[NOTE_W-1:0];
        d4 = d[DUR_W-1:0];
        return {n6, d4};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < SEQ_LEN; i++) mem_m[i] = '0;
    endtask

    initial begin
        bus.strb_i = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.play_i = 1'b0;
        bus.stop_i = 1'b0;
        bus.loop_i = 1'b0;
`ifdef MELODY_SEQ_TEMPO_EN
        bus.tempo_i = 4'(TEMPO);
`endif
        repeat (3) @(negedge clk);
        check("reset", 32'(obs()), 32'd0);
        rst_n = 1'b1;

        // basic: {5,2},{9,1},end
        clear_mem();
        mem_m[0] = ent(5, 2); mem_m[1] = ent(9, 1); mem_m[2] = ent(0, 0);
        load_all(); set_strb(0, 10);
        run("basic", 130, 0, -1);

        // rest then end
        clear_mem();
        mem_m[0] = ent(0, 3); mem_m[1] = ent(0, 0);
        load_all(); set_strb(0, 4);
        run("rest", 80, 0, -1);

        // loop {7,1},end until stop
        clear_mem();
        mem_m[0] = ent(7, 1); mem_m[1] = ent(0, 0);
        load_all(); set_strb(1, 0);
        run("loop", 160, 1, 150);

        // empty melody with loop set
        clear_mem();
        mem_m[0] = ent(33, 0);
        load_all(); set_strb(1, 0);
        run("empty", 12, 1, -1);

        // wrap through all 16 entries
        for (int i = 0; i < SEQ_LEN; i++) mem_m[i] = ent(i + 1, 1);
        load_all(); set_strb(0, 3);
        run("wrap", 260, 0, -1);
        run("wraploop", 300, 1, 290);

        // randomized melodies
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                mem_m[i] = ent(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63)),
                               ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3)));
            end
            load_all(); set_strb(1, 0);
            run($sformatf("rnd%0d", k), 300, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(20, 290)));
        end

        // async reset mid-PLAY, between clock edges
        clear_mem();
        mem_m[0] = ent(12, 3);
        load_all();
        bus.loop_i = 1'b0;
        @(negedge clk); bus.play_i = 1'b1;
        @(negedge clk); bus.play_i = 1'b0;
        repeat (3) @(negedge clk);
        check("midplay", 32'(obs()), 32'(pack(1, 0, 1, 0, 6'd12)));
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(obs()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("after_reset", 32'(obs()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
